// File: rtl/input_autorepeat.sv
// Key conditioning for tetris_game: 2-FF sync + debounce per key, then one-clk action
// pulses with DAS/ARR auto-shift on left/right, soft-drop repeat, one-shot rotate/drop.
module input_autorepeat #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DAS_TICKS       = 10,
  parameter int ARR_TICKS       = 2,
  parameter int SOFT_TICKS      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic hold,
  input  logic key_left_in,
  input  logic key_right_in,
  input  logic key_down_in,
  input  logic key_rotate_in,
  input  logic key_drop_in,
  output logic move_left,
  output logic move_right,
  output logic move_down,
  output logic rotate,
  output logic drop
);

  localparam int NK = 5;
  localparam int KL = 0;
  localparam int KR = 1;
  localparam int KD = 2;
  localparam int KO = 3;
  localparam int KP = 4;

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  DAS_LAST  = 8'(DAS_TICKS - 1);
  localparam logic [7:0]  ARR_LAST  = 8'(ARR_TICKS - 1);
  localparam logic [7:0]  SOFT_LAST = 8'(SOFT_TICKS - 1);

  typedef enum logic [1:0] {
    LR_IDLE,
    LR_DELAY,
    LR_REPEAT
  } lr_state_e;

  typedef enum logic {
    DN_IDLE,
    DN_REPEAT
  } dn_state_e;

  logic [NK-1:0] keys_raw;
  logic [NK-1:0] sync1_q, sync1_d;
  logic [NK-1:0] sync2_q, sync2_d;
  logic [NK-1:0] deb_q, deb_d;
  logic [NK-1:0] deb_prev_q, deb_prev_d;
  logic [NK-1:0] armed_q, armed_d;
  logic [19:0]   db_cnt_q [NK];
  logic [19:0]   db_cnt_d [NK];

  lr_state_e     lr_state_q, lr_state_d;
  logic          lr_dir_q, lr_dir_d;
  logic [7:0]    lr_cnt_q, lr_cnt_d;
  dn_state_e     dn_state_q, dn_state_d;
  logic [7:0]    dn_cnt_q, dn_cnt_d;
  logic [NK-1:0] out_q, out_d;

  logic [NK-1:0] rise, fall, press;
  logic          lr_fire, dn_fire;
  logic          active_held, other_ready;

  assign keys_raw = {key_drop_in, key_rotate_in, key_down_in, key_right_in, key_left_in};

  assign rise  = deb_q & ~deb_prev_q;
  assign fall  = ~deb_q & deb_prev_q;
  assign press = rise & armed_q;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    sync1_d    = keys_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < NK; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // A key held while hold is active stays disarmed until it is released.
  always_comb begin
    armed_d = armed_q | fall;
    if (hold) begin
      armed_d = armed_d & ~deb_q;
    end
  end

  // Shared left/right channel: lr_dir_q picks the active direction (0 = left).
  always_comb begin
    lr_state_d  = lr_state_q;
    lr_dir_d    = lr_dir_q;
    lr_cnt_d    = lr_cnt_q;
    lr_fire     = 1'b0;
    active_held = lr_dir_q ? deb_q[KR] : deb_q[KL];
    other_ready = lr_dir_q ? (deb_q[KL] & armed_q[KL]) : (deb_q[KR] & armed_q[KR]);
    if (hold) begin
      lr_state_d = LR_IDLE;
      lr_cnt_d   = '0;
    end else if (press[KL] || press[KR]) begin
      lr_dir_d   = ~press[KL];
      lr_state_d = LR_DELAY;
      lr_cnt_d   = '0;
      lr_fire    = 1'b1;
    end else if (lr_state_q != LR_IDLE && !active_held) begin
      lr_cnt_d = '0;
      if (other_ready) begin
        lr_dir_d   = ~lr_dir_q;
        lr_state_d = LR_DELAY;
        lr_fire    = 1'b1;
      end else begin
        lr_state_d = LR_IDLE;
      end
    end else if (tick_game) begin
      case (lr_state_q)
        LR_DELAY: begin
          if (lr_cnt_q == DAS_LAST) begin
            lr_fire    = 1'b1;
            lr_cnt_d   = '0;
            lr_state_d = LR_REPEAT;
          end else begin
            lr_cnt_d = lr_cnt_q + 8'd1;
          end
        end
        LR_REPEAT: begin
          if (lr_cnt_q == ARR_LAST) begin
            lr_fire  = 1'b1;
            lr_cnt_d = '0;
          end else begin
            lr_cnt_d = lr_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dn_state_d = dn_state_q;
    dn_cnt_d   = dn_cnt_q;
    dn_fire    = 1'b0;
    if (hold) begin
      dn_state_d = DN_IDLE;
      dn_cnt_d   = '0;
    end else if (press[KD]) begin
      dn_state_d = DN_REPEAT;
      dn_cnt_d   = '0;
      dn_fire    = 1'b1;
    end else if (dn_state_q == DN_REPEAT) begin
      if (!deb_q[KD]) begin
        dn_state_d = DN_IDLE;
        dn_cnt_d   = '0;
      end else if (tick_game) begin
        if (dn_cnt_q == SOFT_LAST) begin
          dn_fire  = 1'b1;
          dn_cnt_d = '0;
        end else begin
          dn_cnt_d = dn_cnt_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    out_d     = '0;
    out_d[KL] = lr_fire & ~lr_dir_d;
    out_d[KR] = lr_fire & lr_dir_d;
    out_d[KD] = dn_fire;
    out_d[KO] = press[KO] & ~hold;
    out_d[KP] = press[KP] & ~hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      armed_q    <= '1;
      for (int i = 0; i < NK; i++) begin
        db_cnt_q[i] <= '0;
      end
      lr_state_q <= LR_IDLE;
      lr_dir_q   <= 1'b0;
      lr_cnt_q   <= '0;
      dn_state_q <= DN_IDLE;
      dn_cnt_q   <= '0;
      out_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      armed_q    <= armed_d;
      for (int i = 0; i < NK; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      lr_state_q <= lr_state_d;
      lr_dir_q   <= lr_dir_d;
      lr_cnt_q   <= lr_cnt_d;
      dn_state_q <= dn_state_d;
      dn_cnt_q   <= dn_cnt_d;
      out_q      <= out_d;
    end
  end

  assign move_left  = out_q[KL];
  assign move_right = out_q[KR];
  assign move_down  = out_q[KD];
  assign rotate     = out_q[KO];
  assign drop       = out_q[KP];

endmodule

// File: tb/tb_input_autorepeat.sv
// Directed bench for input_autorepeat: pulses are logged as {output index, cycle}
// and compared against hand-computed event lists (DEBOUNCE=4, DAS=3, ARR=2, SOFT=1).
module tb_input_autorepeat;

  logic clk = 1'b0;
  logic rst, tick_game, hold;
  logic key_left_in, key_right_in, key_down_in, key_rotate_in, key_drop_in;
  logic move_left, move_right, move_down, rotate, drop;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  always #5 clk = ~clk;

  input_autorepeat #(
    .DEBOUNCE_CYCLES(4),
    .DAS_TICKS(3),
    .ARR_TICKS(2),
    .SOFT_TICKS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_game(tick_game),
    .hold(hold),
    .key_left_in(key_left_in),
    .key_right_in(key_right_in),
    .key_down_in(key_down_in),
    .key_rotate_in(key_rotate_in),
    .key_drop_in(key_drop_in),
    .move_left(move_left),
    .move_right(move_right),
    .move_down(move_down),
    .rotate(rotate),
    .drop(drop)
  );

  // Event encoding: output index 0=left 1=right 2=down 3=rotate 4=drop.
  function automatic logic [15:0] ev(input int idx, input int cyc);
    return {4'(idx), 12'(cyc)};
  endfunction

  task automatic set_keys(input logic [4:0] k);
    key_left_in   = k[0];
    key_right_in  = k[1];
    key_down_in   = k[2];
    key_rotate_in = k[3];
    key_drop_in   = k[4];
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    hold = 1'b0;
    tick_game = 1'b0;
    set_keys(5'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Inputs for relative cycle c; a pulse seen after the following edge is logged at c+1.
  task automatic step(input int c, input logic [4:0] k, input logic h, input logic r);
    logic [4:0] outs;
    set_keys(k);
    hold = h;
    rst = r;
    tick_game = ((c % 10) == 9);
    @(negedge clk);
    outs = {drop, rotate, move_down, move_right, move_left};
    for (int i = 0; i < 5; i++) begin
      if (outs[i]) got_q.push_back(ev(i, c + 1));
    end
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    rst = 1'b1;
    hold = 1'b0;
    tick_game = 1'b1;
    set_keys(5'b11111);
    repeat (3) @(negedge clk);
    outs = {drop, rotate, move_down, move_right, move_left};
    n_cmp++;
    if (outs !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b need %b", outs, 5'b0);
    end
  endtask

  task automatic test_tap_left();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      k = '0;
      k[0] = (c < 20);
      step(c, k, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(0, 7));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL tap_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL tap_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  task automatic test_right_repeat();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 260; c++) begin
      k = '0;
      k[1] = (c < 200);
      step(c, k, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(1, 7));
    for (int t = 30; t <= 190; t += 20) exp_q.push_back(ev(1, t));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL right_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL right_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  task automatic test_bounce_rotate();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 80; c++) begin
      k = '0;
      k[3] = (c < 30) ? (((c / 2) % 2) == 1) : 1'b1;
      step(c, k, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(3, 37));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bounce_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bounce_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  task automatic test_left_right_conflict();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 200; c++) begin
      k = '0;
      k[0] = (c < 50);
      k[1] = (c < 150);
      step(c, k, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(0, 7));
    exp_q.push_back(ev(0, 30));
    exp_q.push_back(ev(0, 50));
    exp_q.push_back(ev(1, 57));
    for (int t = 80; t <= 140; t += 20) exp_q.push_back(ev(1, t));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL conflict_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL conflict_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  task automatic test_soft_drop();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 100; c++) begin
      k = '0;
      k[2] = (c < 72);
      step(c, k, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(2, 7));
    for (int t = 10; t <= 70; t += 10) exp_q.push_back(ev(2, t));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL down_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL down_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  task automatic test_hold_drop();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 100; c++) begin
      k = '0;
      k[4] = (c < 40) || (c >= 60 && c < 80);
      step(c, k, (c < 20), 1'b0);
    end
    exp_q.push_back(ev(4, 67));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL hold_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL hold_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [4:0] k;
    apply_reset();
    for (int c = 0; c < 95; c++) begin
      k = '0;
      k[0] = 1'b1;
      step(c, k, 1'b0, (c >= 49 && c <= 52));
    end
    exp_q.push_back(ev(0, 7));
    exp_q.push_back(ev(0, 30));
    exp_q.push_back(ev(0, 60));
    exp_q.push_back(ev(0, 90));
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL midrst_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midrst_event %0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 16'hffff, exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    tick_game = 1'b0;
    set_keys(5'b0);
    @(negedge clk);
    test_reset();
    test_tap_left();
    test_right_repeat();
    test_bounce_rotate();
    test_left_right_conflict();
    test_soft_drop();
    test_hold_drop();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_autorepeat.md
Name: input_autorepeat

Overview:
- Input-conditioning stage directly upstream of tetris_game.
- Takes the raw merged key levels (PS/2 decode OR board buttons) and synchronizes and debounces them.
- Emits one-cycle action pulses with Tetris-style delayed auto-shift (DAS) and auto-repeat (ARR) on left/right, fixed-rate repeat on soft drop, and one-shot rotate/hard-drop.
- Replaces the per-key input_synchronizer instances and the raw level drive of left/right/down; runs in the 25 MHz game_clk domain.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk samples required to change a debounced level (10 ms at 25 MHz); range 1..2^20-1.
- DAS_TICKS, 10, tick_game pulses between the initial left/right move and the first repeat; range 1..255.
- ARR_TICKS, 2, tick_game pulses between subsequent left/right repeats; range 1..255.
- SOFT_TICKS, 2, tick_game pulses between soft-drop repeats; range 1..255.

Ports:
- clk  in  1  game clock (25 MHz)
- rst  in  1  synchronous active-high reset
- tick_game  in  1  one-clk 60 Hz game tick
- hold  in  1  suppress all actions (e.g. game_over)
- key_left_in  in  1  raw asynchronous level
- key_right_in  in  1  raw asynchronous level
- key_down_in  in  1  raw asynchronous level
- key_rotate_in  in  1  raw asynchronous level
- key_drop_in  in  1  raw asynchronous level
- move_left  out  1  one-clk action pulse
- move_right  out  1  one-clk action pulse
- move_down  out  1  one-clk action pulse
- rotate  out  1  one-clk action pulse
- drop  out  1  one-clk action pulse

Behaviour:
- Reset: all outputs 0; synchronizers, debounced levels and debounce counters 0; all channel FSMs IDLE; all armed flags 1.
- Sync and debounce, per key:
  - 2-FF synchronizer, then a debouncer.
  - The debounced level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clks.
  - Any agreeing sample clears the counter.
  - Raw edge to debounced edge = DEBOUNCE_CYCLES+2 clks.
- Press event: debounced 0->1 with armed=1. The action pulse is asserted in the next clk, so raw edge to pulse = DEBOUNCE_CYCLES+3 clks.
- rotate/drop: exactly one pulse per press event; no repeat.
- left/right FSM (IDLE, DELAY, REPEAT), 8-bit tick counter:
  - IDLE --press--> pulse, count=0, DELAY.
  - DELAY: count tick_game; when the count reaches DAS_TICKS, pulse in the following clk, count=0, go to REPEAT.
  - REPEAT: every ARR_TICKS ticks, pulse in the following clk.
  - Debounced release in any state: go to IDLE the same clk; no pulse.
  - A tick arriving in the press cycle is not counted.
- down FSM (IDLE, REPEAT): press gives an immediate pulse; then one pulse every SOFT_TICKS ticks while held; release goes to IDLE.
- Left/right conflict:
  - Only the most recently pressed direction is active; the other is forced to IDLE with no pulses.
  - Same-cycle press of both: left wins.
  - When the active direction is released while the other is still held, the other restarts as a fresh press (immediate pulse, then DAS).
- hold=1:
  - All outputs 0 and all FSMs forced to IDLE.
  - Every key whose debounced level is 1 is disarmed (armed=0).
  - A key re-arms only on its debounced release. No pulse is generated on hold deassert for keys held through it.
- Outputs are registered and are 1 for exactly one clk per event.
- Simultaneous pulses on different outputs in the same clk are legal (e.g. move_left and rotate).
- Reset asserted mid-operation: state returns to reset values in the next clk; no pulse is emitted in that clk.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, DAS_TICKS=3, ARR_TICKS=2, SOFT_TICKS=1, tick_game every 10 clks.
- Tap left: key_left_in high for 20 clks from cycle 0 -> move_left=1 at cycle 7 only; no other outputs.
- Hold right for 200 clks -> one immediate pulse, the next after 3 ticks, then one every 2 ticks; stops within DEBOUNCE_CYCLES+3 clks of release.
- Bounce: key_rotate_in toggles every 2 clks for 30 clks, then settles high -> exactly one rotate pulse, 7 clks after settling; zero pulses during bouncing.
- Left and right pressed in the same cycle and held, then left released -> left pulses only while held; after left release, right pulses immediately, then follows DAS timing.
- Hold down -> move_down once at press and then once every tick; release mid-interval -> no further pulse.
- drop held while hold=1, then hold=0 with drop still held -> no drop pulse; release and re-press -> one drop pulse; rst asserted during a REPEAT sequence -> all outputs 0 from the next clk.
